// File: rtl/cgr_pkg.sv
// Shared definitions for the CGR pipeline: default geometry, histogram FSM
// state encoding and the 2-bit nucleotide symbol encoding.
package cgr_pkg;

  localparam int unsigned CGR_ADDR_W = 16;
  localparam int unsigned CGR_CNT_W  = 16;
  localparam int unsigned CGR_WARMUP = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } hist_state_e;

  // Symbol encoding used by the CGR address stage (corner of the unit square).
  typedef enum logic [1:0] {
    SYM_A = 2'b00,
    SYM_C = 2'b01,
    SYM_G = 2'b10,
    SYM_T = 2'b11
  } cgr_sym_e;

endpackage

// File: rtl/cgr_hist_if.sv
// Count-request, clear and readout signals between the CGR address stage /
// analysis back end (master) and the histogram engine (slave).
interface cgr_hist_if
  import cgr_pkg::*;
#(
  parameter int unsigned ADDR_W = CGR_ADDR_W,
  parameter int unsigned CNT_W  = CGR_CNT_W
);

  logic [ADDR_W-1:0] addr;
  logic              wen_cgr;
  logic              clr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [31:0]       total_cnt;
  logic              sat;
  logic              busy;

  modport master (
    output addr, wen_cgr, clr, rd_en, rd_addr,
    input  rd_ready, rd_valid, rd_data, total_cnt, sat, busy
  );

  modport slave (
    input  addr, wen_cgr, clr, rd_en, rd_addr,
    output rd_ready, rd_valid, rd_data, total_cnt, sat, busy
  );

endinterface

// File: rtl/cgr_hist_ram.sv
// Histogram storage: 1R1W, synchronous read, returns old data when the read
// and write hit the same cell in one cycle. Contents are not reset.
module cgr_hist_ram
  import cgr_pkg::*;
#(
  parameter int unsigned ADDR_W = CGR_ADDR_W,
  parameter int unsigned CNT_W  = CGR_CNT_W
) (
  input  logic              CLK,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CNT_W-1:0]  rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CNT_W-1:0]  wdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [CNT_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; sees the array before this cycle's write.
  always_ff @(posedge CLK) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cgr_hist.sv
// CGR histogram engine: per-cell saturating occupancy counters kept in RAM
// through a 2-stage read-modify-write pipeline, with warm-up discard,
// a shared readout port, a running k-mer total and a clear sweep.
module cgr_hist
  import cgr_pkg::*;
#(
  parameter int unsigned ADDR_W = CGR_ADDR_W,
  parameter int unsigned CNT_W  = CGR_CNT_W,
  parameter int unsigned WARMUP = CGR_WARMUP
) (
  input logic       CLK,
  input logic       RST,
  cgr_hist_if.slave bus
);

  localparam int unsigned      WCW       = $clog2(WARMUP + 2);
  localparam logic [WCW-1:0]   WARM_DONE = WCW'(WARMUP);
  localparam logic [ADDR_W-1:0] P_LAST   = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [31:0]       TOT_MAX  = '1;

  hist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d;

  logic [WCW-1:0]    warm_q;
  logic [31:0]       total_q;
  logic              sat_q;

  logic              s1_v_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic              fwd_v_q;
  logic [ADDR_W-1:0] fwd_addr_q;
  logic [CNT_W-1:0]  fwd_data_q;
  logic              rd_valid_q;

  logic              running;
  logic              clearing;
  logic              q_req;
  logic              rd_acc;
  logic [CNT_W-1:0]  ram_rdata;
  logic [CNT_W-1:0]  cur;
  logic [CNT_W-1:0]  nxt;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [CNT_W-1:0]  ram_wdata;

  assign running  = (state_q == ST_RUN);
  assign clearing = (state_q == ST_CLEAR);

  // Qualified count request; it owns the RAM read port this cycle.
  assign q_req  = running && bus.wen_cgr && (warm_q == WARM_DONE);
  assign rd_acc = bus.rd_en && bus.rd_ready;

  // FSM state and sweep pointer register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
    end
  end

  // Next state: clr always (re)starts the sweep at cell 0.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    case (state_q)
      ST_CLEAR: begin
        if (bus.clr) begin
          p_d = '0;
        end else if (p_q == P_LAST) begin
          state_d = ST_RUN;
          p_d     = '0;
        end else begin
          p_d = p_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.clr) begin
          state_d = ST_CLEAR;
          p_d     = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        p_d     = '0;
      end
    endcase
  end

  // S1 read value: a write committed in the previous cycle to the same cell
  // is not yet visible in the RAM read data, so take it from the forward reg.
  always_comb begin
    cur = ram_rdata;
    if (fwd_v_q && (fwd_addr_q == s1_addr_q)) cur = fwd_data_q;
    nxt = (cur == CNT_MAX) ? cur : cur + CNT_W'(1);
  end

  // RAM port steering: S0 has priority on the read port; the sweep owns the
  // write port in CLEAR. An S1 write coinciding with clr/RST is dropped.
  always_comb begin
    ram_re    = q_req || rd_acc;
    ram_raddr = q_req ? bus.addr : bus.rd_addr;
    ram_we    = 1'b0;
    ram_waddr = s1_addr_q;
    ram_wdata = nxt;
    if (!RST) begin
      if (clearing) begin
        ram_we    = 1'b1;
        ram_waddr = p_q;
        ram_wdata = '0;
      end else begin
        ram_we = s1_v_q && !bus.clr;
      end
    end
  end

  // Pipeline, warm-up, total and sticky saturation; cleared on RST and clr.
  always_ff @(posedge CLK) begin
    if (RST || bus.clr) begin
      warm_q     <= '0;
      total_q    <= '0;
      sat_q      <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_addr_q  <= '0;
      fwd_v_q    <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
    end else begin
      s1_v_q     <= q_req;
      s1_addr_q  <= bus.addr;
      fwd_v_q    <= s1_v_q;
      fwd_addr_q <= s1_addr_q;
      fwd_data_q <= nxt;
      if (running && bus.wen_cgr && (warm_q != WARM_DONE)) warm_q <= warm_q + WCW'(1);
      if (s1_v_q && (total_q != TOT_MAX)) total_q <= total_q + 32'd1;
      if (s1_v_q && (nxt == CNT_MAX)) sat_q <= 1'b1;
    end
  end

  // Readout response flag; an accepted read always completes.
  always_ff @(posedge CLK) begin
    if (RST) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_acc;
  end

  cgr_hist_ram #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_ram (
    .CLK  (CLK),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata)
  );

  assign bus.rd_ready  = running && !q_req;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_valid_q ? ram_rdata : '0;
  assign bus.total_cnt = total_q;
  assign bus.sat       = sat_q;
  assign bus.busy      = clearing;

endmodule
